ft1248_device: RTL
==================

FT1248_DEVICE -- requirements
Module: ft1248_device

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning per-direction FIFO depth in bytes (power of two, >=2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops on ft_clk_i, ft_ssn_i, ft_miosio_i.
REQ-003 SHALL have port clk_i  input  1  system clock; the one clock; all state on its rising edge.
REQ-004 SHALL have port nrst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports ft_clk_i, ft_ssn_i, ft_miosio_i  input  1 each  FT1248 SCLK, SS_N and MIOSIO driven by the SoC master.
REQ-006 SHALL have ports ft_miso_o, ft_miosio_o, ft_miosio_e, ft_miosio_z  output  1 each  device status, MIOSIO drive, active-high enable, active-low enable (always ~ft_miosio_e).
REQ-007 SHALL have ports tx_data_i  input  8, tx_valid_i  input  1, tx_ready_o  output  1  host bytes to send to SoC.
REQ-008 SHALL have ports rx_data_o  output  8, rx_valid_o  output  1, rx_ready_i  input  1  bytes received from SoC.

Function
REQ-009 SHALL be the 1-bit FT1248 responder (device end) for the nanosoc FT1248 master; clk_i >= 4x ft_clk_i frequency.
REQ-010 SHALL detect ft_clk_i rise/fall edges on the synchronised signal only.
REQ-011 SHALL implement states IDLE, CMD, TURN, DATA_WR, DATA_RD, IGNORE.
REQ-012 SHALL move IDLE->CMD on synchronised ft_ssn_i low; any state ->IDLE on synchronised ft_ssn_i high, discarding partial bytes, no FIFO push/pop.
REQ-013 SHALL in CMD shift 8 bits MSB-first on ft_clk rises; after bit 8: 8'h00 (WRITE) or 8'h40 (READ) ->TURN, otherwise ->IGNORE.
REQ-014 SHALL keep TURN for one ft_clk period (next rise) then enter DATA_WR or DATA_RD; data bytes LSB-first, back-to-back while ft_ssn_i low.
REQ-015 SHALL in DATA_WR sample MIOSIO on rises; on bit 8 push byte into RX FIFO if ACKed; ft_miosio_e=0.
REQ-016 SHALL in DATA_RD assert ft_miosio_e from the TURN fall until IDLE, update ft_miosio_o on each fall, pop TX FIFO after the 8th rise of an ACKed byte.
REQ-017 SHALL decide ACK/NAK at the first bit of each byte and hold it for the byte: WRITE NAK if RX FIFO full, READ NAK if TX FIFO empty; NAK byte not pushed/popped, READ NAK drives 1s.
REQ-018 SHALL drive ft_miso_o: IDLE = 0 when TX FIFO non-empty else 1; CMD/TURN = 0; DATA = 0 on ACK, 1 on NAK; IGNORE = 1.
REQ-019 SHALL provide tx_ready_o = TX FIFO not full, rx_valid_o = RX FIFO not empty, rx_data_o = RX FIFO head; transfer when valid&&ready.
REQ-020 SHALL accept simultaneous host push and device pop (and vice versa) on a full/empty FIFO without loss; pointers wrap modulo DEPTH.
REQ-021 SHALL present a received byte on rx_valid_o within 2 clk_i of the detected 8th rise.

Reset
REQ-022 SHALL on nrst_i low force IDLE, empty FIFOs, synchronisers to idle (ft_clk 0, ft_ssn 1), ft_miso_o=1, ft_miosio_o=0, ft_miosio_e=0, ft_miosio_z=1, tx_ready_o=1, rx_valid_o=0, rx_data_o=0.

Configuration
REQ-023 SHALL with FT1248_DEVICE_LOOPBACK_EN defined push WRITE bytes into TX FIFO (NAK when TX full), tie tx_ready_o=0, rx_valid_o=0, ignore tx_*/rx_ready_i; without it, behaviour as REQ-015/019.

Structure
REQ-024 SHALL place command codes (8'h00, 8'h40) and the state enum in shared package ft1248_pkg.
REQ-025 SHALL use one sub-module ft1248_device_fifo (parameter DEPTH, 8-bit), instantiated twice.

Verification
REQ-026 Reset mid-DATA_RD -> all outputs at REQ-022 values while nrst_i low; IDLE after release.
REQ-027 WRITE 8'h00 + data 8'hA5 -> rx_data_o=8'hA5, rx_valid_o=1 within 2 clk_i; ft_miso_o=0 during data.
REQ-028 Host pushes 8'h3C -> idle ft_miso_o=0; READ 8'h40 -> master samples 8'h3C LSB-first; then ft_miso_o=1 idle.
REQ-029 Five WRITE bytes, rx_ready_i=0, DEPTH=4 -> 5th byte ft_miso_o=1, discarded, FIFO holds first four in order.
REQ-030 ft_ssn_i high after 3 data bits -> no push, IDLE, ft_miosio_e=0 within SYNC_STAGES+1 clk_i.
REQ-031 Command 8'h7E -> IGNORE, ft_miso_o=1, no FIFO change; FT1248_DEVICE_LOOPBACK_EN build: WRITE 8'h5A then READ returns 8'h5A.

Source files
------------

// File: rtl/ft1248_pkg.sv
// Shared definitions for the FT1248 device-side responder:
// command codes and the protocol state enumeration.
package ft1248_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h40;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    TURN    = 3'd2,
    DATA_WR = 3'd3,
    DATA_RD = 3'd4,
    IGNORE  = 3'd5
  } ft_state_e;

endpackage

// File: rtl/ft1248_device_fifo.sv
// Byte FIFO used for both directions of the FT1248 device.
// DEPTH must be a power of two >= 2; pointers carry one extra wrap bit.
// The head is presented combinationally and reads as zero while empty.
module ft1248_device_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  assign rdata_o = empty_o ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values, wrapping naturally modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/ft1248_device.sv
// FT1248 1-bit device-side responder.
// The SoC master's SCLK/SS_N/MIOSIO are synchronised into clk_i and all
// protocol timing is taken from edges of the synchronised SCLK.
// Build option: FT1248_DEVICE_LOOPBACK_EN routes WRITE bytes straight into
// the TX FIFO so that a following READ returns them; the host ports are idle.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | SS_N high; MISO advertises whether TX data is waiting
// CMD     | shifting in the 8-bit command, MSB first
// TURN    | one SCLK period of bus turnaround; device takes MIOSIO on READ
// DATA_WR | receiving bytes LSB first, pushing ACKed bytes into RX FIFO
// DATA_RD | sending TX FIFO bytes LSB first, popping ACKed bytes
// IGNORE  | unknown command; wait for SS_N high
module ft1248_device
  import ft1248_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       ft_clk_i,
  input  logic       ft_ssn_i,
  input  logic       ft_miosio_i,
  output logic       ft_miso_o,
  output logic       ft_miosio_o,
  output logic       ft_miosio_e,
  output logic       ft_miosio_z,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i
);

  // SYNC_STAGES is expected to be >= 2.
  logic [SYNC_STAGES-1:0] clk_sync_q, ssn_sync_q, mio_sync_q;
  logic                   clk_prev_q;
  logic                   clk_s, ssn_s, mio_s, rise, fall;

  ft_state_e  state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] cmd_q, cmd_d;
  logic [6:0] data_q, data_d;
  logic       is_read_q, is_read_d;
  logic       ack_q, ack_d;
  logic       oe_q, oe_d;
  logic       mio_q, mio_d;

  logic [7:0] cmd_nxt, wr_byte;
  logic       ack_now, miso;
  logic       wr_push, tx_pop;
  logic       wr_full;

  logic       tx_push, rx_push, rx_pop;
  logic [7:0] tx_wdata, tx_head, rx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;

  // Input synchronisers, reset to an idle bus (SCLK low, SS_N high).
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      clk_sync_q <= '0;
      ssn_sync_q <= '1;
      mio_sync_q <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ft_clk_i};
      ssn_sync_q <= {ssn_sync_q[SYNC_STAGES-2:0], ft_ssn_i};
      mio_sync_q <= {mio_sync_q[SYNC_STAGES-2:0], ft_miosio_i};
      clk_prev_q <= clk_s;
    end
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign ssn_s = ssn_sync_q[SYNC_STAGES-1];
  assign mio_s = mio_sync_q[SYNC_STAGES-1];
  assign rise  = clk_s && !clk_prev_q;
  assign fall  = !clk_s && clk_prev_q;

  assign cmd_nxt = {cmd_q, mio_s};
  assign wr_byte = {mio_s, data_q};

  // Protocol state and datapath registers.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      is_read_q <= 1'b0;
      ack_q     <= 1'b0;
      oe_q      <= 1'b0;
      mio_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cmd_q     <= cmd_d;
      data_q    <= data_d;
      is_read_q <= is_read_d;
      ack_q     <= ack_d;
      oe_q      <= oe_d;
      mio_q     <= mio_d;
    end
  end

  // Next-state logic; SS_N high aborts any transfer without touching the FIFOs.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cmd_d     = cmd_q;
    data_d    = data_q;
    is_read_d = is_read_q;
    ack_d     = ack_q;
    oe_d      = oe_q;
    mio_d     = mio_q;
    ack_now   = ack_q;
    wr_push   = 1'b0;
    tx_pop    = 1'b0;
    if (ssn_s) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      oe_d      = 1'b0;
      mio_d     = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = '0;
          cmd_d     = '0;
        end
        CMD: begin
          if (rise) begin
            cmd_d     = cmd_nxt[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (cmd_nxt == CMD_WRITE) begin
                state_d   = TURN;
                is_read_d = 1'b0;
              end else if (cmd_nxt == CMD_READ) begin
                state_d   = TURN;
                is_read_d = 1'b1;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end
        TURN: begin
          if (fall && is_read_q) oe_d = 1'b1;
          if (rise) begin
            state_d   = is_read_q ? DATA_RD : DATA_WR;
            bit_cnt_d = '0;
            // Provisional status so MISO is meaningful before the first bit.
            ack_d     = is_read_q ? !tx_empty : !wr_full;
          end
        end
        DATA_WR: begin
          if (rise) begin
            if (bit_cnt_q == 3'd0) ack_now = !wr_full;
            ack_d     = ack_now;
            data_d    = wr_byte[7:1];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && ack_now) wr_push = 1'b1;
          end
        end
        DATA_RD: begin
          if (fall) begin
            if (bit_cnt_q == 3'd0) ack_now = !tx_empty;
            ack_d = ack_now;
            mio_d = ack_now ? tx_head[bit_cnt_q] : 1'b1;
          end
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && ack_q) tx_pop = 1'b1;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // MISO status: TX-data-waiting in IDLE, ACK/NAK during data.
  always_comb begin
    miso = 1'b1;
    unique case (state_q)
      IDLE:             miso = tx_empty;
      CMD, TURN:        miso = 1'b0;
      DATA_WR, DATA_RD: miso = !ack_q;
      default:          miso = 1'b1;
    endcase
  end

  assign ft_miso_o   = miso;
  assign ft_miosio_o = mio_q;
  assign ft_miosio_e = oe_q;
  assign ft_miosio_z = !oe_q;

`ifdef FT1248_DEVICE_LOOPBACK_EN
  logic unused_lb;
  assign unused_lb  = ^{tx_data_i, tx_valid_i, rx_ready_i, rx_head, rx_full, rx_empty};
  assign wr_full    = tx_full;
  assign tx_push    = wr_push;
  assign tx_wdata   = wr_byte;
  assign rx_push    = 1'b0;
  assign rx_pop     = 1'b0;
  assign tx_ready_o = 1'b0;
  assign rx_valid_o = 1'b0;
  assign rx_data_o  = 8'h00;
`else
  assign wr_full    = rx_full;
  assign tx_push    = tx_valid_i;
  assign tx_wdata   = tx_data_i;
  assign rx_push    = wr_push;
  assign rx_pop     = rx_ready_i;
  assign tx_ready_o = !tx_full;
  assign rx_valid_o = !rx_empty;
  assign rx_data_o  = rx_head;
`endif

  ft1248_device_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (tx_push),
    .wdata_i (tx_wdata),
    .pop_i   (tx_pop),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  ft1248_device_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .push_i  (rx_push),
    .wdata_i (wr_byte),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

endmodule
